// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional feature macro: WRITE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_mp_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_NUM_REGS   = 32;
  localparam int unsigned RF_X0         = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks x1..x(NUM_REGS-1) writing zero after reset or on request.
module regfile_clear_seq
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NUM_REGS   = RF_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_idx
);

  localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(NUM_REGS - 1);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // State and clear pointer registers, synchronous reset restarts the walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      ptr_q   <= IDX_FIRST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: advance through the file, leave on the last index; requests only honoured in READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_CLEAR: begin
        if (ptr_q == IDX_LAST) begin
          state_d = RF_READY;
        end else begin
          ptr_d = ptr_q + IDX_FIRST;
        end
      end
      RF_READY: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          ptr_d   = IDX_FIRST;
        end
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  assign busy    = (state_q == RF_CLEAR);
  assign clr_we  = busy;
  assign clr_idx = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Two-read / two-write integer register file with x0 hard-wired to zero.
// Optional feature macro: WRITE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = RF_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic                  wr_a,
  input  logic [ADDR_WIDTH-1:0] rd_a,
  input  logic [DATA_WIDTH-1:0] wd_a,
  input  logic                  wr_b,
  input  logic [ADDR_WIDTH-1:0] rd_b,
  input  logic [DATA_WIDTH-1:0] wd_b,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] IDX_X0 = ADDR_WIDTH'(RF_X0);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  ok_a, ok_b, ok_1, ok_2;
  logic                  we_a, we_b;

  regfile_clear_seq #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  // Index range checks only exist when the index space is larger than the file.
  if (NUM_REGS == (1 << ADDR_WIDTH)) begin : g_full_range
    assign ok_a = 1'b1;
    assign ok_b = 1'b1;
    assign ok_1 = 1'b1;
    assign ok_2 = 1'b1;
  end else begin : g_part_range
    assign ok_a = 32'(rd_a) < NUM_REGS;
    assign ok_b = 32'(rd_b) < NUM_REGS;
    assign ok_1 = 32'(rs1) < NUM_REGS;
    assign ok_2 = 32'(rs2) < NUM_REGS;
  end

  // Writes are dropped while clearing, to x0, and to indices outside the file.
  assign we_a = wr_a && (rd_a != IDX_X0) && ok_a && !busy;
  assign we_b = wr_b && (rd_b != IDX_X0) && ok_b && !busy;

  // Storage update: clear walk first, then lane B over lane A on a shared index.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr_we && (clr_idx == ADDR_WIDTH'(i))) begin
        regs_q[i] <= '0;
      end else if (we_b && (rd_b == ADDR_WIDTH'(i))) begin
        regs_q[i] <= wd_b;
      end else if (we_a && (rd_a == ADDR_WIDTH'(i))) begin
        regs_q[i] <= wd_a;
      end
    end
  end

  // Read port 1: zero for x0, out-of-range or while clearing.
  always_comb begin
    rd1 = '0;
    if (!busy && (rs1 != IDX_X0) && ok_1) begin
      rd1 = regs_q[rs1];
`ifdef WRITE_BYPASS_EN
      if (we_b && (rd_b == rs1)) begin
        rd1 = wd_b;
      end else if (we_a && (rd_a == rs1)) begin
        rd1 = wd_a;
      end
`endif
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2 = '0;
    if (!busy && (rs2 != IDX_X0) && ok_2) begin
      rd2 = regs_q[rs2];
`ifdef WRITE_BYPASS_EN
      if (we_b && (rd_b == rs2)) begin
        rd2 = wd_b;
      end else if (we_a && (rd_a == rs2)) begin
        rd2 = wd_a;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected read/busy values, a monitor checks them.
module tb_regfile_mp;

`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clear_req;
  logic [4:0]  rs1, rs2, rd_a, rd_b;
  logic [31:0] rd1, rd2, wd_a, wd_b;
  logic        wr_a, wr_b, busy;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd1       (rd1),
    .rd2       (rd2),
    .wr_a      (wr_a),
    .rd_a      (rd_a),
    .wd_a      (wd_a),
    .wr_b      (wr_b),
    .rd_b      (rd_b),
    .wd_b      (wd_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: inputs change just after posedge, outputs are checked on the negedge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (rd1 !== e.e1 || rd2 !== e.e2 || busy !== e.eb) begin
        n_miss++;
        $display("FAIL %s: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                 e.nm, rd1, rd2, busy, e.e1, e.e2, e.eb);
      end
    end
  end

  task automatic push_exp(input logic [31:0] e1, input logic [31:0] e2, input logic eb,
                          input string nm);
    exp_t e;
    e.e1 = e1; e.e2 = e2; e.eb = eb; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; clear_req = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
  endtask

  task automatic wa(input logic [4:0] a, input logic [31:0] d);
    wr_a = 1'b1; rd_a = a; wd_a = d;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wr_b = 1'b1; rd_b = a; wd_b = d;
  endtask

  // Expects busy=1 and zero reads every clear cycle; a reset restarts the 31-cycle count.
  task automatic run_clear(input int wr4_at, input int clr_at, input int rst_at, input string nm);
    int remaining;
    int c;
    remaining = 31;
    c = 0;
    while (remaining > 0) begin
      quiet();
      rs1 = 5'd5; rs2 = 5'd1;
      if (c == wr4_at) wa(5'd4, 32'd7);
      if (c == clr_at) clear_req = 1'b1;
      if (c == rst_at) rst = 1'b1;
      push_exp(32'd0, 32'd0, 1'b1, nm);
      tick();
      remaining = (c == rst_at) ? 31 : remaining - 1;
      c++;
    end
    quiet();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear_req = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    rs1 = '0; rs2 = '0; rd_a = '0; rd_b = '0; wd_a = '0; wd_b = '0;
    tick();
    run_clear(-1, -1, -1, "reset_busy");

    // Fill every register so the next reset has something to clear.
    for (int i = 1; i < 32; i++) begin
      quiet();
      wa(5'(i), 32'hDEADBEEF);
      rs1 = '0; rs2 = '0;
      if (i == 1) push_exp(32'd0, 32'd0, 1'b0, "ready_after_clear");
      tick();
    end
    quiet(); rs1 = 5'd1; rs2 = 5'd31;
    push_exp(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "preload");
    tick();

    rst = 1'b1;
    push_exp(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "rst_cycle");
    tick();
    run_clear(-1, -1, -1, "rst_busy");
    for (int i = 1; i < 32; i += 2) begin
      quiet(); rs1 = 5'(i); rs2 = 5'(i + 1);
      push_exp(32'd0, 32'd0, 1'b0, "cleared");
      tick();
    end

    // Dual write to distinct indices.
    quiet(); wa(5'd1, 32'd5); wb(5'd2, 32'd10); rs1 = 5'd3; rs2 = 5'd4;
    push_exp(32'd0, 32'd0, 1'b0, "dual_wr_cycle");
    tick();
    quiet(); rs1 = 5'd1; rs2 = 5'd2;
    push_exp(32'd5, 32'd10, 1'b0, "dual_rd");
    tick();

    // Same-index collision and x0 writes.
    quiet(); wa(5'd3, 32'h11); wb(5'd3, 32'h22); rs1 = 5'd1; rs2 = 5'd2;
    push_exp(32'd5, 32'd10, 1'b0, "collision_cycle");
    tick();
    quiet(); wa(5'd0, 32'hFF); wb(5'd0, 32'hFF); rs1 = 5'd3; rs2 = 5'd0;
    push_exp(32'h22, 32'd0, 1'b0, "collision");
    tick();
    quiet(); rs1 = 5'd0; rs2 = 5'd3;
    push_exp(32'd0, 32'h22, 1'b0, "x0_write");
    tick();

    // Same-cycle read of a committing write.
    quiet(); wa(5'd5, 32'h123); rs1 = 5'd2; rs2 = 5'd1;
    push_exp(32'd10, 32'd5, 1'b0, "pre_bypass");
    tick();
    quiet(); wb(5'd5, 32'hABC); wa(5'd6, 32'h66); rs1 = 5'd5; rs2 = 5'd6;
    push_exp(BYP ? 32'hABC : 32'h123, BYP ? 32'h66 : 32'd0, 1'b0, "bypass");
    tick();
    quiet(); wa(5'd7, 32'd1); wb(5'd7, 32'd2); rs1 = 5'd7; rs2 = 5'd0;
    push_exp(BYP ? 32'd2 : 32'd0, 32'd0, 1'b0, "bypass_prio");
    tick();
    quiet(); rs1 = 5'd5; rs2 = 5'd6;
    push_exp(32'hABC, 32'h66, 1'b0, "post_bypass");
    tick();
    quiet(); rs1 = 5'd7; rs2 = 5'd3;
    push_exp(32'd2, 32'h22, 1'b0, "prio_stored");
    tick();

    // Clear request from READY, with a write in the same cycle, writes and requests while busy.
    quiet(); clear_req = 1'b1; wa(5'd8, 32'h88); rs1 = 5'd5; rs2 = 5'd3;
    push_exp(32'hABC, 32'h22, 1'b0, "clr_req_cycle");
    tick();
    run_clear(3, 10, -1, "clr_req_busy");
    quiet(); rs1 = 5'd4; rs2 = 5'd8;
    push_exp(32'd0, 32'd0, 1'b0, "wr_during_busy");
    tick();

    // Reset in the middle of a clear restarts the walk.
    quiet(); wb(5'd9, 32'h99); rs1 = 5'd0; rs2 = 5'd0;
    push_exp(32'd0, 32'd0, 1'b0, "pre_restart_wr");
    tick();
    quiet(); clear_req = 1'b1; rs1 = 5'd9; rs2 = 5'd0;
    push_exp(32'h99, 32'd0, 1'b0, "pre_restart_rd");
    tick();
    run_clear(-1, -1, 10, "rst_restart");
    quiet(); rs1 = 5'd9; rs2 = 5'd5;
    push_exp(32'd0, 32'd0, 1'b0, "after_restart");
    tick();

    quiet();
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
